// File: rtl/s382_light_monitor.sv
// On-line observer for the s382 traffic-light lamps: decodes the six lamp drives into a
// phase code, measures per-phase dwell and raises sticky flags for encoding, conflict, order and short-yellow faults.
module s382_light_monitor #(
   parameter int DW      = 8,
   parameter int MIN_YLW = 3
) (
   input  logic          CK,
   input  logic          CLRN,
   input  logic          GRN1,
   input  logic          YLW1,
   input  logic          RED1,
   input  logic          GRN2,
   input  logic          YLW2,
   input  logic          RED2,
   input  logic          ERRCLR,
   output logic [2:0]    PHASE,
   output logic [DW-1:0] DWELL,
   output logic [DW-1:0] LAST_DWELL,
   output logic          PHASE_CHG,
   output logic          SYNCED,
   output logic          ERR_ENC,
   output logic          ERR_CONFLICT,
   output logic          ERR_SEQ,
   output logic          ERR_SHORT,
   output logic          ERR_ANY
);

   typedef enum logic {
      SYNC  = 1'b0,
      TRACK = 1'b1
   } state_t;

   localparam logic [DW-1:0] DWELL_MAX = '1;
   localparam logic [DW-1:0] DWELL_ONE = {{(DW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0] YLW_MIN   = DW'(MIN_YLW);

   // Stage 1: lamp register. lamp_vld keeps the cleared register from being judged as an encoding fault.
   logic [5:0] lamp_q;
   logic       lamp_vld;

   always_ff @(posedge CK) begin
      if (!CLRN) begin
         lamp_q   <= '0;
         lamp_vld <= 1'b0;
      end else begin
         lamp_q   <= {GRN1, YLW1, RED1, GRN2, YLW2, RED2};
         lamp_vld <= 1'b1;
      end
   end

   logic [2:0] dir1;
   logic [2:0] dir2;
   logic       enc_bad;
   logic       conflict;
   logic [2:0] code;

   always_comb begin
      dir1     = lamp_q[5:3];
      dir2     = lamp_q[2:0];
      enc_bad  = !$onehot(dir1) || !$onehot(dir2);
      conflict = !enc_bad && !dir1[0] && !dir2[0];
      case ({dir1, dir2})
         6'b100_001: code = 3'd0;
         6'b010_001: code = 3'd1;
         6'b001_001: code = 3'd2;
         6'b001_100: code = 3'd3;
         6'b001_010: code = 3'd4;
         default:    code = 3'd7;
      endcase
   end

   // lastdir: 0 = all-red was entered from direction-1 yellow, 1 = from direction-2 yellow.
   state_t        state, state_nx;
   logic          lastdir, lastdir_nx;
   logic [2:0]    phase_nx;
   logic [DW-1:0] dwell_nx;
   logic [DW-1:0] last_nx;
   logic          chg_nx;
   logic          succ_ok;
   logic          seq_hit;
   logic          short_hit;
   logic          enc_hit;
   logic          conf_hit;
   logic          err_enc_nx, err_conf_nx, err_seq_nx, err_short_nx;

   always_comb begin
      succ_ok = 1'b0;
      case (PHASE)
         3'd0:    succ_ok = (code == 3'd1);
         3'd1:    succ_ok = (code == 3'd2) || (code == 3'd3);
         3'd2:    succ_ok = lastdir ? (code == 3'd0) : (code == 3'd3);
         3'd3:    succ_ok = (code == 3'd4);
         3'd4:    succ_ok = (code == 3'd2) || (code == 3'd0);
         default: succ_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_nx   = state;
      phase_nx   = PHASE;
      dwell_nx   = DWELL;
      last_nx    = LAST_DWELL;
      chg_nx     = 1'b0;
      lastdir_nx = lastdir;
      seq_hit    = 1'b0;
      short_hit  = 1'b0;
      if (lamp_vld) begin
         case (state)
            SYNC: begin
               if (code != 3'd7) begin
                  phase_nx = code;
                  dwell_nx = DWELL_ONE;
                  chg_nx   = 1'b1;
                  state_nx = TRACK;
               end else begin
                  phase_nx = 3'd7;
                  dwell_nx = '0;
               end
            end
            TRACK: begin
               if (code == 3'd7) begin
                  phase_nx = 3'd7;
                  dwell_nx = '0;
                  last_nx  = DWELL;
                  chg_nx   = 1'b1;
                  state_nx = SYNC;
               end else if (code == PHASE) begin
                  if (DWELL != DWELL_MAX) dwell_nx = DWELL + DWELL_ONE;
               end else begin
                  // A yellow is judged short only when a legal phase takes over from it.
                  seq_hit   = !succ_ok;
                  short_hit = ((PHASE == 3'd1) || (PHASE == 3'd4)) && (DWELL < YLW_MIN);
                  if (PHASE == 3'd1) lastdir_nx = 1'b0;
                  if (PHASE == 3'd4) lastdir_nx = 1'b1;
                  phase_nx = code;
                  last_nx  = DWELL;
                  dwell_nx = DWELL_ONE;
                  chg_nx   = 1'b1;
               end
            end
            default: state_nx = SYNC;
         endcase
      end
   end

   // A fresh error outranks ERRCLR in the same cycle.
   always_comb begin
      enc_hit      = lamp_vld && enc_bad;
      conf_hit     = lamp_vld && conflict;
      err_enc_nx   = (ERR_ENC && !ERRCLR) || enc_hit;
      err_conf_nx  = (ERR_CONFLICT && !ERRCLR) || conf_hit;
      err_seq_nx   = (ERR_SEQ && !ERRCLR) || seq_hit;
      err_short_nx = (ERR_SHORT && !ERRCLR) || short_hit;
   end

   always_ff @(posedge CK) begin
      if (!CLRN) begin
         state        <= SYNC;
         lastdir      <= 1'b0;
         PHASE        <= 3'd7;
         DWELL        <= '0;
         LAST_DWELL   <= '0;
         PHASE_CHG    <= 1'b0;
         ERR_ENC      <= 1'b0;
         ERR_CONFLICT <= 1'b0;
         ERR_SEQ      <= 1'b0;
         ERR_SHORT    <= 1'b0;
         ERR_ANY      <= 1'b0;
      end else begin
         state        <= state_nx;
         lastdir      <= lastdir_nx;
         PHASE        <= phase_nx;
         DWELL        <= dwell_nx;
         LAST_DWELL   <= last_nx;
         PHASE_CHG    <= chg_nx;
         ERR_ENC      <= err_enc_nx;
         ERR_CONFLICT <= err_conf_nx;
         ERR_SEQ      <= err_seq_nx;
         ERR_SHORT    <= err_short_nx;
         ERR_ANY      <= err_enc_nx | err_conf_nx | err_seq_nx | err_short_nx;
      end
   end

   assign SYNCED = (state == TRACK);

endmodule
